// File: rtl/sram_port_arbiter_pkg.sv
// Shared constants for the unified-memory SRAM arbiter: response owner encoding,
// default bus widths and the fetch starvation limit.
package sram_port_arbiter_pkg;

    localparam int ADDR_W_DEF       = 32;
    localparam int DATA_W_DEF       = 32;
    localparam int STARVE_LIMIT_DEF = 4;

    // Owner of the SRAM access whose read data arrives in the current cycle.
    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_INST = 2'd1,
        RESP_DATA = 2'd2
    } resp_t;

endpackage

// File: rtl/sram_port_arbiter_arb_starve_counter.sv
// Saturating count of consecutive cycles the fetch side has lost arbitration;
// at_limit lets the fetch request override data priority.
module arb_starve_counter #(
    parameter  int LIMIT = 4,
    localparam int W     = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    logic [W-1:0] count;

    assign at_limit = (count == W'(LIMIT));

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !at_limit) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port synchronous SRAM between instruction fetch and data access.
// Data has priority; a starvation counter forces a fetch grant after STARVE_LIMIT losses.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,
    input  logic                data_req,
    input  logic [DATA_W/8-1:0] data_we,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                sram_en,
    output logic [DATA_W/8-1:0] sram_we,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [DATA_W-1:0]   sram_wdata,
    input  logic [DATA_W-1:0]   sram_rdata
);

    logic  grant_data;
    logic  grant_inst;
    logic  at_limit;
    resp_t state;
    resp_t state_next;

    arb_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .reset    (reset),
        .inc      (inst_req && grant_data),
        .clr      (grant_inst || !inst_req),
        .at_limit (at_limit)
    );

    // Grants are suppressed during reset so no access can start while the FSM is clearing.
    always_comb begin
        grant_data = !reset && data_req && !(inst_req && at_limit);
        grant_inst = !reset && inst_req && !grant_data;
    end

    always_comb begin
        inst_addr_ok = grant_inst;
        data_addr_ok = grant_data;
        sram_en      = grant_inst || grant_data;
        sram_we      = '0;
        sram_addr    = '0;
        sram_wdata   = '0;
        if (grant_data) begin
            sram_we    = data_we;
            sram_addr  = data_addr;
            sram_wdata = data_wdata;
        end else if (grant_inst) begin
            sram_addr  = inst_addr;
        end
    end

    // The owner register always tracks the grant of the previous cycle, so a
    // cycle without a grant returns it to RESP_NONE and no response repeats.
    always_comb begin
        state_next   = RESP_NONE;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        inst_rdata   = '0;
        data_rdata   = '0;
        if (grant_data) begin
            state_next = RESP_DATA;
        end else if (grant_inst) begin
            state_next = RESP_INST;
        end
        if (!reset && state == RESP_INST) begin
            inst_data_ok = 1'b1;
            inst_rdata   = sram_rdata;
        end
        if (!reset && state == RESP_DATA) begin
            data_data_ok = 1'b1;
            data_rdata   = sram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RESP_NONE;
        end else begin
            state <= state_next;
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: SRAM model, behavioural arbitration/response model
// compared every cycle, directed scenarios pinned with literal values, then random traffic.
module tb_sram_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;
    localparam int LIMIT  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [DATA_W-1:0] inst_rdata;
    logic              data_req;
    logic [STRB_W-1:0] data_we;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;
    logic              sram_en;
    logic [STRB_W-1:0] sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata = '0;

    int n_checks = 0;
    int n_fail   = 0;

    sram_port_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_we      (data_we),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .sram_en      (sram_en),
        .sram_we      (sram_we),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Power-up contents of a word never written.
    function automatic logic [DATA_W-1:0] init_word(input logic [ADDR_W-1:0] a);
        if (a == 32'h1c000000) return 32'h02800c04;
        if (a == 32'h00000100) return 32'h00000000;
        return a * 32'h9e3779b1;
    endfunction

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                                input logic [DATA_W-1:0] wd,
                                                input logic [STRB_W-1:0] we);
        logic [DATA_W-1:0] r;
        r = old;
        for (int b = 0; b < STRB_W; b++) begin
            if (we[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        end
        return r;
    endfunction

    // ---------------- SRAM model (driven by DUT sram_* outputs) ----------------
    logic [DATA_W-1:0] sram_mem [0:1023];
    bit                sram_wr  [0:1023];
    logic [9:0]        sidx;
    assign sidx = sram_addr[11:2];

    always @(posedge clk) begin
        if (sram_en) begin
            sram_rdata <= sram_wr[sidx] ? sram_mem[sidx] : init_word(sram_addr);
            if (sram_we != '0) begin
                sram_mem[sidx] <= merge(sram_wr[sidx] ? sram_mem[sidx] : init_word(sram_addr),
                                        sram_wdata, sram_we);
                sram_wr[sidx]  <= 1'b1;
            end
        end
    end

    // ---------------- behavioural reference model ----------------
    logic [DATA_W-1:0] ref_mem [0:1023];
    bit                ref_wr  [0:1023];
    int                wait_cnt = 0;   // consecutive cycles the fetch request was refused
    logic              exp_gi = 1'b0;
    logic              exp_gd = 1'b0;
    logic [DATA_W-1:0] exp_q[$];
    bit                owner_q[$];     // 1 = inst, 0 = data
    bit                wr_q[$];

    function automatic logic [DATA_W-1:0] ref_read(input logic [ADDR_W-1:0] a);
        return ref_wr[a[11:2]] ? ref_mem[a[11:2]] : init_word(a);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            wait_cnt <= 0;
        end else begin
            wait_cnt <= (inst_req && !exp_gi) ? ((wait_cnt < LIMIT) ? wait_cnt + 1 : wait_cnt) : 0;
            if (exp_gd) begin
                owner_q.push_back(1'b0);
                wr_q.push_back(data_we != '0);
                exp_q.push_back(ref_read(data_addr));
                if (data_we != '0) begin
                    ref_mem[data_addr[11:2]] <= merge(ref_read(data_addr), data_wdata, data_we);
                    ref_wr[data_addr[11:2]]  <= 1'b1;
                end
            end else if (exp_gi) begin
                owner_q.push_back(1'b1);
                wr_q.push_back(1'b0);
                exp_q.push_back(ref_read(inst_addr));
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        logic              gd, gi, have, own, wr;
        logic [DATA_W-1:0] rd;
        gd = !reset && data_req && !(inst_req && wait_cnt >= LIMIT);
        gi = !reset && inst_req && !gd;
        exp_gd <= gd;
        exp_gi <= gi;
        check("inst_addr_ok", inst_addr_ok, gi);
        check("data_addr_ok", data_addr_ok, gd);
        check("sram_en", sram_en, gd || gi);
        check("sram_we", sram_we, gd ? data_we : '0);
        check("sram_addr", sram_addr, gd ? data_addr : (gi ? inst_addr : '0));
        if (!gi) check("sram_wdata", sram_wdata, gd ? data_wdata : '0);

        have = 1'b0; own = 1'b0; wr = 1'b0; rd = '0;
        if (owner_q.size() > 0) begin
            have = !reset;
            own  = owner_q.pop_front();
            wr   = wr_q.pop_front();
            rd   = exp_q.pop_front();
        end
        check("inst_data_ok", inst_data_ok, have && own);
        check("data_data_ok", data_data_ok, have && !own);
        check("inst_rdata", inst_rdata, (have && own) ? rd : '0);
        if (!(have && !own && wr)) check("data_rdata", data_rdata, (have && !own) ? rd : '0);
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [ADDR_W-1:0] rand_addr();
        return 32'h200 + 4 * $urandom_range(0, 15);
    endfunction

    logic [9:0] pat10;
    logic [4:0] pat5;

    initial begin
        reset      = 1'b1;
        inst_req   = 1'b1;
        data_req   = 1'b1;
        inst_addr  = 32'h1c000000;
        data_addr  = 32'h00000300;
        data_we    = '0;
        data_wdata = '0;

        // Reset held 3 cycles with both requests up: everything quiet.
        repeat (3) begin
            @(negedge clk);
            check("lit_reset_quiet",
                  {inst_addr_ok, data_addr_ok, sram_en, sram_we, inst_data_ok, data_data_ok},
                  '0);
            tick();
        end
        reset = 1'b0;
        @(negedge clk);
        check("lit_first_grant_data", data_addr_ok, 1'b1);
        tick();

        // Fetch alone: accepted at N, data back at N+1.
        data_req = 1'b0;
        @(negedge clk);
        check("lit_fetch_addr_ok", inst_addr_ok, 1'b1);
        tick();
        inst_req = 1'b0;
        @(negedge clk);
        check("lit_fetch_data_ok", {inst_data_ok, data_data_ok}, 2'b10);
        check("lit_fetch_rdata", inst_rdata, 32'h02800c04);
        tick();

        // Both requesting every cycle: D,D,D,D,I repeating.
        inst_req = 1'b1;
        data_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            pat10[i] = inst_addr_ok;
            tick();
        end
        check("lit_starve_pattern", pat10, 10'b1000010000);

        // Partial write then read-back.
        inst_req   = 1'b0;
        data_req   = 1'b1;
        data_we    = 4'b0011;
        data_addr  = 32'h100;
        data_wdata = 32'hdeadbeef;
        @(negedge clk);
        check("lit_write_sram_we", sram_we, 4'b0011);
        check("lit_write_sram_wdata", sram_wdata, 32'hdeadbeef);
        tick();
        data_we = '0;
        @(negedge clk);
        check("lit_write_data_ok", data_data_ok, 1'b1);
        tick();
        data_req = 1'b0;
        @(negedge clk);
        check("lit_readback", {data_data_ok, data_rdata}, {1'b1, 32'h0000beef});
        tick();

        // Back-to-back inst, data, inst grants.
        inst_req = 1'b1;
        @(negedge clk);
        check("lit_b2b_grant_i", {inst_addr_ok, data_addr_ok}, 2'b10);
        tick();
        inst_req = 1'b0;
        data_req = 1'b1;
        @(negedge clk);
        check("lit_b2b_grant_d", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 4'b0110);
        tick();
        inst_req = 1'b1;
        data_req = 1'b0;
        @(negedge clk);
        check("lit_b2b_grant_i2", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 4'b1001);
        tick();
        inst_req = 1'b0;
        @(negedge clk);
        check("lit_b2b_last_resp", {inst_data_ok, data_data_ok}, 2'b10);
        tick();

        // Reset right after a data read grant, with fetch partly starved.
        inst_req  = 1'b1;
        data_req  = 1'b1;
        data_addr = 32'h300;
        repeat (3) tick();
        reset = 1'b1;
        @(negedge clk);
        check("lit_reset_drops_resp", data_data_ok, 1'b0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            pat5[i] = inst_addr_ok;
            tick();
        end
        check("lit_starve_cleared_by_reset", pat5, 5'b10000);

        // Random traffic honouring the hold-until-accepted rule.
        for (int c = 0; c < 2000; c++) begin
            if (!inst_req || exp_gi) begin
                inst_req  = ($urandom_range(0, 3) != 0);
                inst_addr = rand_addr();
            end
            if (!data_req || exp_gd) begin
                data_req   = ($urandom_range(0, 2) != 0);
                data_addr  = rand_addr();
                data_we    = ($urandom_range(0, 1) == 1) ? STRB_W'($urandom) : '0;
                data_wdata = $urandom;
            end
            reset = ($urandom_range(0, 99) == 0);
            tick();
        end

        reset    = 1'b0;
        inst_req = 1'b0;
        data_req = 1'b0;
        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
